// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states and flag-register bit positions for the sequential ALU
package alu_seq_pkg;
  localparam int OC_ADD = 0;
  localparam int OC_SUB = 1;
  localparam int OC_XOR = 2;
  localparam int OC_AND = 3;
  localparam int OC_OR  = 4;
  localparam int OC_ADC = 5;
  localparam int OC_SBC = 6;
  localparam int OC_SHL = 7;
  localparam int OC_SHR = 8;
  localparam int OC_MUL = 9;
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
  localparam int F_C = 0;
  localparam int F_Z = 1;
  localparam int F_N = 2;
  localparam int F_V = 3;
  localparam int F_W = 4;
endpackage

// File: rtl/carry_ripple_adder.sv
// carry_ripple_adder: WIDTH-bit ripple-carry adder
//   a_i, b_i : addends
//   carry_i  : carry into bit 0
//   sum_o    : WIDTH-bit sum
//   carry_o  : carry out of the MSB
module carry_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  logic [WIDTH:0] c;
  assign c[0] = carry_i;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign carry_o = c[WIDTH];
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/valid handshake, carry-chained arithmetic and iterative shift/multiply
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   start_i            : request, accepted when start_i & ready_o
//   a_i, b_i, oc_i     : operands and opcode, sampled on accept
//   ready_o, valid_o   : idle indicator, one-cycle completion pulse
//   result_o           : result, held until the next completion
//   result_hi_o        : upper half of the MUL product, 0 otherwise
//   carry_o, zero_o, neg_o, ovf_o, illegal_o : status flags, updated on completion
// Define ALU_MUL_EN to build the iterative shift-add multiplier (opcode 9);
// without it opcode 9 is illegal and result_hi_o is tied to 0.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int ALU_BIT_WIDTH        = 4,
  parameter int OPERATION_CODE_WIDTH = 4,
  parameter int SHIFT_CNT_WIDTH      = $clog2(ALU_BIT_WIDTH) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            start_i,
  input  logic [ALU_BIT_WIDTH-1:0]        a_i,
  input  logic [ALU_BIT_WIDTH-1:0]        b_i,
  input  logic [OPERATION_CODE_WIDTH-1:0] oc_i,
  output logic                            ready_o,
  output logic                            valid_o,
  output logic [ALU_BIT_WIDTH-1:0]        result_o,
  output logic [ALU_BIT_WIDTH-1:0]        result_hi_o,
  output logic                            carry_o,
  output logic                            zero_o,
  output logic                            neg_o,
  output logic                            ovf_o,
  output logic                            illegal_o
);
  localparam int W = ALU_BIT_WIDTH;
  localparam int M = W - 1;
  localparam int CW = SHIFT_CNT_WIDTH;
`ifdef ALU_MUL_EN
  localparam int OC_MAX = OC_MUL;
`else
  localparam int OC_MAX = OC_SHR;
`endif
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d, n;
  logic [W-1:0] lo, lo_d, res_d, sum, add_b;
  logic [OPERATION_CODE_WIDTH-1:0] oc_q;
  logic [31:0] op, op_q;
  logic [F_W-1:0] fl;
  logic done, c_d, v_d, ill_d, arith, sub, add_c, add_co, legal, shift;
`ifdef ALU_MUL_EN
  logic [W-1:0] hi, hi_d, mc, rhi_d;
  logic [W:0] psum;
`endif
  assign op = 32'(oc_i);
  assign op_q = 32'(oc_q);
  assign arith = op inside {OC_ADD, OC_SUB, OC_ADC, OC_SBC};
  assign sub = op == OC_SUB || op == OC_SBC;
  assign shift = op == OC_SHL || op == OC_SHR;
  assign legal = op <= OC_MAX;
  assign add_b = sub ? ~b_i : b_i;
  // ADD/SUB seed the chain with the subtract bit; ADC/SBC chain in the stored carry
  assign add_c = (op == OC_ADD || op == OC_SUB) ? sub : fl[F_C];
  // Shifts by W or more still only need W single-bit steps
  assign n = 32'(b_i) > W ? CW'(W) : CW'(b_i);
  carry_ripple_adder #(.WIDTH(W)) u_add (
    .a_i(a_i), .b_i(add_b), .carry_i(add_c), .sum_o(sum), .carry_o(add_co)
  );
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    lo_d = lo;
    done = 1'b0;
    res_d = '0;
    c_d = fl[F_C];
    v_d = 1'b0;
    ill_d = 1'b0;
`ifdef ALU_MUL_EN
    hi_d = hi;
    rhi_d = '0;
    psum = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
`endif
    case (state)
      S_IDLE: if (start_i) begin
        if (shift && n != '0) begin
          state_d = S_ITER;
          cnt_d = n;
          lo_d = a_i;
        end
`ifdef ALU_MUL_EN
        else if (op == OC_MUL) begin
          state_d = S_ITER;
          cnt_d = CW'(W);
          lo_d = b_i;
          hi_d = '0;
        end
`endif
        else begin
          state_d = S_DONE;
          done = 1'b1;
          res_d = arith ? sum : op == OC_XOR ? a_i ^ b_i : op == OC_AND ? a_i & b_i :
                  op == OC_OR ? a_i | b_i : shift ? a_i : '0;
          c_d = arith ? add_co : legal ? 1'b0 : fl[F_C];
          v_d = arith & (a_i[M] == add_b[M]) & (sum[M] != a_i[M]);
          ill_d = !legal;
        end
      end
      S_ITER: begin
        cnt_d = cnt - CW'(1);
        if (op_q == OC_SHL) begin
          lo_d = {lo[M-1:0], 1'b0};
          c_d = lo[M];
        end else if (op_q == OC_SHR) begin
          lo_d = {1'b0, lo[M:1]};
          c_d = lo[0];
        end
`ifdef ALU_MUL_EN
        else begin
          // lo holds the unconsumed multiplier bits; product bits shift in from the top
          {hi_d, lo_d} = {psum, lo[M:1]};
          rhi_d = hi_d;
          c_d = hi_d != '0;
        end
`endif
        if (cnt == CW'(1)) begin
          state_d = S_DONE;
          done = 1'b1;
          res_d = lo_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= S_IDLE;
    else state <= state_d;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
      lo <= '0;
      oc_q <= '0;
      result_o <= '0;
      fl <= '0;
      illegal_o <= 1'b0;
`ifdef ALU_MUL_EN
      hi <= '0;
      mc <= '0;
      result_hi_o <= '0;
`endif
    end else begin
      cnt <= cnt_d;
      lo <= lo_d;
      if (start_i && state == S_IDLE) oc_q <= oc_i;
      if (done) begin
        result_o <= res_d;
        fl[F_C] <= c_d;
        fl[F_Z] <= res_d == '0;
        fl[F_N] <= res_d[M];
        fl[F_V] <= v_d;
        illegal_o <= ill_d;
      end
`ifdef ALU_MUL_EN
      hi <= hi_d;
      if (start_i && state == S_IDLE) mc <= a_i;
      if (done) result_hi_o <= rhi_d;
`endif
    end
  end
`ifndef ALU_MUL_EN
  assign result_hi_o = '0;
`endif
  assign ready_o = state == S_IDLE;
  assign valid_o = state == S_DONE;
  assign carry_o = fl[F_C];
  assign zero_o = fl[F_Z];
  assign neg_o = fl[F_N];
  assign ovf_o = fl[F_V];
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with directed vectors
module tb_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] a = '0, b = '0, oc = '0;
  logic ready, valid, carry, zero, neg, ovf, ill;
  logic [3:0] res, rhi;
  typedef struct {string tag; logic [3:0] r, h; logic c, z, n, v, i; int cyc;} exp_t;
  exp_t q[$];
  exp_t me;
  int total = 0, bad = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  alu_seq dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .a_i(a), .b_i(b), .oc_i(oc),
    .ready_o(ready), .valid_o(valid), .result_o(res), .result_hi_o(rhi),
    .carry_o(carry), .zero_o(zero), .neg_o(neg), .ovf_o(ovf), .illegal_o(ill)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  function automatic exp_t mk(input string t, input logic [3:0] r, h, input logic c, z, n, v, i);
    exp_t e;
    e.tag = t; e.r = r; e.h = h; e.c = c; e.z = z; e.n = n; e.v = v; e.i = i; e.cyc = 0;
    return e;
  endfunction
  always @(negedge clk) if (valid === 1'b1) begin
    if (q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
    else begin
      me = q.pop_front();
      chk({me.tag, ".cycle"}, me.cyc == cyc ? 32'd1 : 32'(cyc), me.cyc == cyc ? 32'd1 : 32'(me.cyc));
      chk({me.tag, ".result"}, 32'(res), 32'(me.r));
      chk({me.tag, ".result_hi"}, 32'(rhi), 32'(me.h));
      chk({me.tag, ".carry"}, 32'(carry), 32'(me.c));
      chk({me.tag, ".zero"}, 32'(zero), 32'(me.z));
      chk({me.tag, ".neg"}, 32'(neg), 32'(me.n));
      chk({me.tag, ".ovf"}, 32'(ovf), 32'(me.v));
      chk({me.tag, ".illegal"}, 32'(ill), 32'(me.i));
    end
  end
  task automatic chk_idle(input string t);
    chk({t, ".result"}, 32'(res), 0);
    chk({t, ".result_hi"}, 32'(rhi), 0);
    chk({t, ".flags"}, 32'({carry, zero, neg, ovf, ill}), 0);
    chk({t, ".valid"}, 32'(valid), 0);
    chk({t, ".ready"}, 32'(ready), 1);
  endtask
  task automatic wait_ready(input string t);
    int k = 0;
    @(negedge clk);
    while (ready !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({t, ".ready_wait"}, 32'(ready), 1);
  endtask
  task automatic issue(input logic [3:0] o, x, y, input exp_t e, input int lat, input bit hold);
    int k = 0;
    wait_ready(e.tag);
    e.cyc = cyc + lat;
    q.push_back(e);
    start = 1'b1; a = x; b = y; oc = o;
    @(posedge clk);
    #1;
    if (hold) begin
      a = '0;
      b = '0;
      while (k < 100) begin
        @(negedge clk);
        if (ready === 1'b1) break;
        k++;
      end
    end
    start = 1'b0;
  endtask
  initial begin
    int k = 0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    issue(4'd0, 4'h7, 4'h9, mk("add", 4'h0, 4'h0, 1, 1, 0, 0, 0), 1, 0);
    issue(4'd1, 4'h3, 4'h5, mk("sub", 4'hE, 4'h0, 0, 0, 1, 0, 0), 1, 0);
    issue(4'd5, 4'h2, 4'h3, mk("adc_c0", 4'h5, 4'h0, 0, 0, 0, 0, 0), 1, 0);
    issue(4'd0, 4'hF, 4'h1, mk("add_wrap", 4'h0, 4'h0, 1, 1, 0, 0, 0), 1, 0);
    issue(4'd5, 4'h2, 4'h3, mk("adc_c1", 4'h6, 4'h0, 0, 0, 0, 0, 0), 1, 0);
    issue(4'd0, 4'h7, 4'h1, mk("add_ovf", 4'h8, 4'h0, 0, 0, 1, 1, 0), 1, 0);
    issue(4'd7, 4'h5, 4'h0, mk("shl0", 4'h5, 4'h0, 0, 0, 0, 0, 0), 1, 0);
    issue(4'd7, 4'hB, 4'h2, mk("shl", 4'hC, 4'h0, 0, 0, 1, 0, 0), 3, 0);
    issue(4'd8, 4'h9, 4'h7, mk("shr_clamp", 4'h0, 4'h0, 1, 1, 0, 0, 0), 5, 0);
`ifdef ALU_MUL_EN
    issue(4'd9, 4'h7, 4'h6, mk("mul", 4'hA, 4'h2, 1, 0, 1, 0, 0), 5, 0);
    issue(4'd9, 4'h7, 4'h6, mk("mul_hold", 4'hA, 4'h2, 1, 0, 1, 0, 0), 5, 1);
`else
    issue(4'd9, 4'h7, 4'h6, mk("mul_ill", 4'h0, 4'h0, 1, 1, 0, 0, 1), 1, 0);
    issue(4'd9, 4'h7, 4'h6, mk("mul_hold", 4'h0, 4'h0, 1, 1, 0, 0, 1), 1, 1);
`endif
    wait_ready("abort");
`ifdef ALU_MUL_EN
    start = 1'b1; a = 4'h7; b = 4'h6; oc = 4'd9;
`else
    start = 1'b1; a = 4'hF; b = 4'h4; oc = 4'd7;
`endif
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk_idle("abort");
    repeat (6) @(negedge clk);
    chk_idle("abort_held");
    rst_n = 1'b1;
    issue(4'd0, 4'hF, 4'h1, mk("add_c1", 4'h0, 4'h0, 1, 1, 0, 0, 0), 1, 0);
    issue(4'hF, 4'h3, 4'h3, mk("illegal", 4'h0, 4'h0, 1, 1, 0, 0, 1), 1, 0);
    issue(4'd2, 4'hA, 4'h5, mk("xor", 4'hF, 4'h0, 0, 0, 1, 0, 0), 1, 0);
    issue(4'd3, 4'hC, 4'hA, mk("and", 4'h8, 4'h0, 0, 0, 1, 0, 0), 1, 0);
    issue(4'd6, 4'h2, 4'h1, mk("sbc_b", 4'h0, 4'h0, 1, 1, 0, 0, 0), 1, 0);
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
